sync_fifo_fwft: RTL and testbench

SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

---
 rtl/sync_fifo_fwft_if.sv | 28 ++
 rtl/sync_fifo_fwft.sv | 87 ++++++++
 tb/tb_sync_fifo_fwft.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle for sync_fifo_fwft: producer/consumer side is master, FIFO is slave.
interface sync_fifo_fwft_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
);
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             almost_full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             err_clr;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en, err_clr,
        input  full, almost_full, dout, empty, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, err_clr,
        output full, almost_full, dout, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with arbitrary depth, selectable first-word-fall-through or
// registered read, occupancy thresholds and sticky overflow/underflow flags.
module sync_fifo_fwft #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 32,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_fwft_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf, r_unf;

    logic             w_empty, w_full, w_rd_acc, w_wr_acc;
    logic [CNT_W:0]   w_cnt_nxt;
    logic [PTR_W-1:0] w_wptr_nxt, w_rptr_nxt;

    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == CNT_W'(DEPTH));
    assign w_rd_acc = bus.rd_en && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a write.
    assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);

    assign w_cnt_nxt  = {1'b0, r_cnt} + (CNT_W+1)'(w_wr_acc) - (CNT_W+1)'(w_rd_acc);
    assign w_wptr_nxt = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
    assign w_rptr_nxt = (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= w_wptr_nxt;
            if (w_rd_acc) begin
                r_rptr <= w_rptr_nxt;
                r_dout <= r_mem[r_rptr];
            end
            r_cnt <= w_cnt_nxt[CNT_W-1:0];
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) r_mem[r_wptr] <= bus.din;
    end

    // A fresh error in the same cycle outranks err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (bus.wr_en && !w_wr_acc) r_ovf <= 1'b1;
            else if (bus.err_clr)       r_ovf <= 1'b0;
            if (bus.rd_en && !w_rd_acc) r_unf <= 1'b1;
            else if (bus.err_clr)       r_unf <= 1'b0;
        end
    end

    // r_dout holds the last popped word; in FWFT mode it only shows while empty.
    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout = w_empty ? r_dout : r_mem[r_rptr];
        end else begin : g_reg
            assign bus.dout = r_dout;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_cnt >= CNT_W'(AFULL_THRESH));
    assign bus.almost_empty = (r_cnt <= CNT_W'(AEMPTY_THRESH));
    assign bus.count        = r_cnt;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Two DEPTH=5 FIFOs (FWFT and registered-read) fed identical stimulus and
// checked against one queue-based reference.
module tb_sync_fifo_fwft;
    localparam int W = 8, D = 5, CW = 3;
    localparam int AF1 = 4, AE1 = 1, AF0 = D - 2, AE0 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_fwft_if #(.WIDTH(W), .CNT_W(CW)) b1 ();
    sync_fifo_fwft_if #(.WIDTH(W), .CNT_W(CW)) b0 ();

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_THRESH(AF1),
                     .AEMPTY_THRESH(AE1), .CNT_W(CW))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    sync_fifo_fwft #(.WIDTH(W), .DEPTH(D), .FWFT(0), .CNT_W(CW))
        dut0 (.clk(clk), .rst(rst), .bus(b0));

    int total = 0, bad = 0;

    // Reference: occupancy is the queue, last popped word, sticky flags.
    logic [7:0] q[$];
    logic [7:0] last = 8'h00;
    logic       ovf = 1'b0, unf = 1'b0;

    function automatic logic [7:0] exp_dout1();
        return (q.size() > 0) ? q[0] : last;
    endfunction

    task automatic tick(input logic wr, input logic rd, input logic [7:0] d,
                        input logic clr, input logic r);
        logic rok, wok;
        b1.wr_en = wr; b1.rd_en = rd; b1.din = d; b1.err_clr = clr;
        b0.wr_en = wr; b0.rd_en = rd; b0.din = d; b0.err_clr = clr;
        rst = r;
        @(posedge clk);
        if (r) begin
            q.delete(); last = 8'h00; ovf = 1'b0; unf = 1'b0;
        end else begin
            rok = rd && (q.size() > 0);
            wok = wr && ((q.size() < D) || rok);
            if (rok) last = q.pop_front();
            if (wok) q.push_back(d);
            if (wr && !wok) ovf = 1'b1; else if (clr) ovf = 1'b0;
            if (rd && !rok) unf = 1'b1; else if (clr) unf = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
        tick(0, 0, 0, 0, 1'b1);
        tick(0, 0, 0, 0, 0);
        total++;
        if ({b1.count, b1.empty, b1.full, b1.almost_empty, b1.almost_full, b1.overflow, b1.underflow}
            !== {3'd0, 6'b101000}) begin
            bad++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b o=%b u=%b want cnt=0 e=1 f=0 ae=1 af=0 o=0 u=0",
                     b1.count, b1.empty, b1.full, b1.almost_empty, b1.almost_full, b1.overflow, b1.underflow);
        end
        total++;
        if (b1.dout !== 8'h00 || b0.dout !== 8'h00) begin
            bad++;
            $display("FAIL reset_dout: got %0h/%0h want 0/0", b1.dout, b0.dout);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 5; i++) tick(1, 0, 8'h11 + 8'(i), 0, 0);
        total++;
        if ({b1.full, b1.count, b1.almost_full, b1.dout} !== {1'b1, 3'd5, 1'b1, 8'h11}) begin
            bad++;
            $display("FAIL fill: got f=%b cnt=%0d af=%b dout=%0h want f=1 cnt=5 af=1 dout=11",
                     b1.full, b1.count, b1.almost_full, b1.dout);
        end
        tick(1, 0, 8'h16, 0, 0);
        total++;
        if ({b1.overflow, b1.count, b1.dout, b0.overflow} !== {1'b1, 3'd5, 8'h11, 1'b1}) begin
            bad++;
            $display("FAIL overflow: got o=%b cnt=%0d dout=%0h o0=%b want o=1 cnt=5 dout=11 o0=1",
                     b1.overflow, b1.count, b1.dout, b0.overflow);
        end
        tick(0, 0, 0, 1, 0);
        total++;
        if (b1.overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got %b want 0", b1.overflow);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] want [5];
        want = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h20};
        tick(1, 1, 8'h20, 0, 0);
        total++;
        if ({b1.dout, b1.count, b1.full, b1.overflow, b0.dout} !== {8'h12, 3'd5, 1'b1, 1'b0, 8'h11}) begin
            bad++;
            $display("FAIL full_rw: got dout=%0h cnt=%0d f=%b o=%b dout0=%0h want 12 5 1 0 11",
                     b1.dout, b1.count, b1.full, b1.overflow, b0.dout);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (b1.dout !== want[i]) begin
                bad++;
                $display("FAIL drain[%0d]: got %0h want %0h", i, b1.dout, want[i]);
            end
            tick(0, 1, 0, 0, 0);
        end
        total++;
        if ({b1.empty, b1.dout, b0.dout} !== {1'b1, 8'h20, 8'h20}) begin
            bad++;
            $display("FAIL drain_end: got e=%b dout=%0h dout0=%0h want 1 20 20", b1.empty, b1.dout, b0.dout);
        end
    endtask

    task automatic test_empty_wr_rd();
        tick(1, 1, 8'hAA, 0, 0);
        total++;
        if ({b1.underflow, b1.count, b1.dout, b1.empty} !== {1'b1, 3'd1, 8'hAA, 1'b0}) begin
            bad++;
            $display("FAIL empty_wr_rd: got u=%b cnt=%0d dout=%0h e=%b want 1 1 aa 0",
                     b1.underflow, b1.count, b1.dout, b1.empty);
        end
        tick(0, 1, 0, 0, 0);
        total++;
        if ({b1.empty, b1.dout, b0.dout} !== {1'b1, 8'hAA, 8'hAA}) begin
            bad++;
            $display("FAIL empty_pop: got e=%b dout=%0h dout0=%0h want 1 aa aa", b1.empty, b1.dout, b0.dout);
        end
        tick(0, 1, 0, 1, 0);
        total++;
        if (b1.underflow !== 1'b1) begin
            bad++;
            $display("FAIL set_beats_clr: got %b want 1", b1.underflow);
        end
        tick(0, 0, 0, 1, 0);
        total++;
        if ({b1.underflow, b0.underflow} !== 2'b00) begin
            bad++;
            $display("FAIL unf_clear: got %b%b want 00", b1.underflow, b0.underflow);
        end
    endtask

    task automatic test_thresholds();
        for (int n = 0; n <= 10; n++) begin
            int c;
            c = (n <= 5) ? n : 10 - n;
            total++;
            if ({b1.count, b1.almost_full, b1.almost_empty, b0.almost_full}
                !== {3'(c), c >= AF1, c <= AE1, c >= AF0}) begin
                bad++;
                $display("FAIL thresh@%0d: got cnt=%0d af=%b ae=%b af0=%b", c,
                         b1.count, b1.almost_full, b1.almost_empty, b0.almost_full);
            end
            if (n < 5) tick(1, 0, 8'(n), 0, 0);
            else if (n < 10) tick(0, 1, 0, 0, 0);
        end
    endtask

    task automatic test_fwft0();
        for (int i = 0; i < 12; i++) begin
            tick(1, 0, 8'(i), 0, 0);
            tick(0, 1, 0, 0, 0);
            total++;
            if (b0.dout !== 8'(i)) begin
                bad++;
                $display("FAIL fwft0_rd[%0d]: got %0h want %0h", i, b0.dout, i);
            end
            tick(0, 0, 0, 0, 0);
            total++;
            if (b0.dout !== 8'(i) || b0.empty !== 1'b1) begin
                bad++;
                $display("FAIL fwft0_hold[%0d]: got %0h e=%b want %0h e=1", i, b0.dout, b0.empty, i);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(1, 0, 8'hC0 + 8'(i), 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(1, 0, 8'hC3, 0, 0);
        tick(1, 0, 8'h00, 0, 0);
        tick(0, 1, 0, 0, 0);
        total++;
        if (b1.count !== 3'd3) begin
            bad++;
            $display("FAIL pre_rst_cnt: got %0d want 3", b1.count);
        end
        tick(1, 1, 8'h77, 0, 1);
        total++;
        if ({b1.count, b1.empty, b1.dout, b0.dout, b1.overflow, b1.underflow}
            !== {3'd0, 1'b1, 8'h00, 8'h00, 2'b00}) begin
            bad++;
            $display("FAIL mid_reset: got cnt=%0d e=%b dout=%0h dout0=%0h o=%b u=%b want 0 1 0 0 0 0",
                     b1.count, b1.empty, b1.dout, b0.dout, b1.overflow, b1.underflow);
        end
        tick(1, 0, 8'h3C, 0, 0);
        tick(0, 1, 0, 0, 0);
        total++;
        if ({b0.dout, b1.dout, b1.empty} !== {8'h3C, 8'h3C, 1'b1}) begin
            bad++;
            $display("FAIL no_stale: got dout0=%0h dout=%0h e=%b want 3c 3c 1", b0.dout, b1.dout, b1.empty);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            tick($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 8'($urandom), $urandom_range(0, 99) < 8, $urandom_range(0, 199) == 0);
            total++;
            if ({b1.count, b1.full, b1.empty, b1.almost_full, b1.almost_empty}
                !== {3'(q.size()), q.size() == D, q.size() == 0, q.size() >= AF1, q.size() <= AE1}) begin
                bad++;
                $display("FAIL rnd_status@%0d: got cnt=%0d f=%b e=%b af=%b ae=%b want cnt=%0d",
                         n, b1.count, b1.full, b1.empty, b1.almost_full, b1.almost_empty, q.size());
            end
            total++;
            if (b1.dout !== exp_dout1() || b0.dout !== last) begin
                bad++;
                $display("FAIL rnd_dout@%0d: got %0h/%0h want %0h/%0h", n, b1.dout, b0.dout, exp_dout1(), last);
            end
            total++;
            if ({b1.overflow, b1.underflow, b0.overflow, b0.underflow, b0.count}
                !== {ovf, unf, ovf, unf, 3'(q.size())}) begin
                bad++;
                $display("FAIL rnd_flags@%0d: got o=%b u=%b o0=%b u0=%b cnt0=%0d want o=%b u=%b cnt=%0d",
                         n, b1.overflow, b1.underflow, b0.overflow, b0.underflow, b0.count, ovf, unf, q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_rw();
        test_empty_wr_rd();
        test_thresholds();
        test_fwft0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
